// File: rtl/piece_move_ctrl_pkg.sv
// Shared types and defaults for the active-piece move controller.
// PIECE_WALL_KICK_EN adds the KICK_L/KICK_R retry states.
package piece_move_ctrl_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int SPAWN_X_DEF = 3;
  localparam int SPAWN_Y_DEF = 0;

  typedef struct packed {
    logic left;
    logic right;
    logic down;
    logic cw;
    logic ccw;
  } buttons_t;

  typedef struct packed {
    logic [3:0] x;
    logic [4:0] y;
    logic [1:0] rot;
  } piece_pose_t;

  typedef enum logic [2:0] {MV_LEFT, MV_RIGHT, MV_DOWN, MV_CW, MV_CCW} move_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
`ifdef PIECE_WALL_KICK_EN
    ST_COMMIT,
    ST_KICK_L,
    ST_KICK_R
`else
    ST_COMMIT
`endif
  } ctrl_state_t;

  // Commands arrive one-hot; the fixed order only matters for malformed input.
  function automatic move_kind_t decode_buttons(input buttons_t b);
    if (b.left)       return MV_LEFT;
    else if (b.right) return MV_RIGHT;
    else if (b.down)  return MV_DOWN;
    else if (b.cw)    return MV_CW;
    else              return MV_CCW;
  endfunction

  function automatic logic is_rotation(input move_kind_t k);
    return (k == MV_CW) || (k == MV_CCW);
  endfunction

endpackage

// File: rtl/piece_move_ctrl_if.sv
// Command, collision-check and pose signals of the piece move controller.
// Handshakes: pressed is consumed in the cycle poll_inputs is high; chk_req is held with stable chk_x/y/rot until the cycle chk_ack is high, chk_collide is valid with chk_ack.
interface piece_move_ctrl_if;
  import piece_move_ctrl_pkg::*;

  buttons_t    pressed;
  logic        poll_inputs;
  logic        gravity_tick;
  logic        spawn;
  logic        chk_req;
  logic [3:0]  chk_x;
  logic [4:0]  chk_y;
  logic [1:0]  chk_rot;
  logic        chk_ack;
  logic        chk_collide;
  logic [3:0]  piece_x;
  logic [4:0]  piece_y;
  logic [1:0]  piece_rot;
  logic        active;
  logic        lock;
  ctrl_state_t state;

  modport master (
    input  pressed, gravity_tick, spawn, chk_ack, chk_collide,
    output poll_inputs, chk_req, chk_x, chk_y, chk_rot,
    output piece_x, piece_y, piece_rot, active, lock, state
  );

  modport slave (
    output pressed, gravity_tick, spawn, chk_ack, chk_collide,
    input  poll_inputs, chk_req, chk_x, chk_y, chk_rot,
    input  piece_x, piece_y, piece_rot, active, lock, state
  );
endinterface

// File: rtl/piece_move_ctrl_candidate.sv
// Combinational candidate pose for one move, with optional x kick offset.
// Arithmetic runs wider than the pose fields so off-board results are caught.
module piece_move_ctrl_candidate
  import piece_move_ctrl_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  piece_pose_t       i_pose,
  input  move_kind_t        i_kind,
  input  logic signed [1:0] i_kick,
  output piece_pose_t       o_cand,
  output logic              o_out_of_range
);

  localparam logic signed [5:0] X_MAX = 6'(BOARD_W - 1);
  localparam logic        [5:0] Y_MAX = 6'(BOARD_H - 1);

  logic signed [5:0] w_x;
  logic        [5:0] w_y;
  logic        [2:0] w_rot;

  always_comb begin
    w_x   = $signed({2'b00, i_pose.x}) + $signed({{4{i_kick[1]}}, i_kick});
    w_y   = {1'b0, i_pose.y};
    w_rot = {1'b0, i_pose.rot};
    case (i_kind)
      MV_LEFT:  w_x   = w_x - 6'sd1;
      MV_RIGHT: w_x   = w_x + 6'sd1;
      MV_DOWN:  w_y   = w_y + 6'd1;
      MV_CW:    w_rot = w_rot + 3'd1;
      MV_CCW:   w_rot = w_rot - 3'd1;
      default:  ;
    endcase
    o_cand.x       = w_x[3:0];
    o_cand.y       = w_y[4:0];
    o_cand.rot     = w_rot[1:0];
    o_out_of_range = (w_x < 6'sd0) || (w_x > X_MAX) || (w_y > Y_MAX);
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Active-piece controller: turns commands and gravity into checked pose moves.
// Define PIECE_WALL_KICK_EN to retry blocked rotations one column left, then right.
module piece_move_ctrl
  import piece_move_ctrl_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int SPAWN_X = SPAWN_X_DEF,
  parameter int SPAWN_Y = SPAWN_Y_DEF
) (
  input logic              clk,
  input logic              reset_n,
  piece_move_ctrl_if.master bus
);

  localparam piece_pose_t SPAWN_POSE = '{x: 4'(SPAWN_X), y: 5'(SPAWN_Y), rot: 2'd0};

  ctrl_state_t r_state;
  piece_pose_t r_pose;
  piece_pose_t r_cand;
  move_kind_t  r_kind;
  logic        r_collide;
  logic        r_active;
  logic        r_grav_pend;
  logic        r_chk_req;
  logic        r_lock;
`ifdef PIECE_WALL_KICK_EN
  logic [1:0]  r_kick_stage;
`endif

  logic              w_grav;
  logic              w_idle_go;
  logic              w_take_grav;
  logic              w_take_btn;
  move_kind_t        w_kind;
  logic signed [1:0] w_kick;
  piece_pose_t       w_cand;
  logic              w_oor;

  // A tick arriving this very cycle already beats a pressed button.
  assign w_grav      = r_active && (r_grav_pend || bus.gravity_tick);
  assign w_idle_go   = (r_state == ST_IDLE) && !bus.spawn;
  assign w_take_grav = w_idle_go && w_grav;
  assign w_take_btn  = w_idle_go && r_active && !w_grav && (bus.pressed != '0);
  assign w_kind      = (r_state != ST_IDLE) ? r_kind :
                       w_grav ? MV_DOWN : decode_buttons(bus.pressed);

`ifdef PIECE_WALL_KICK_EN
  assign w_kick = (r_state == ST_KICK_L) ? -2'sd1 :
                  (r_state == ST_KICK_R) ?  2'sd1 : 2'sd0;
`else
  assign w_kick = 2'sd0;
`endif

  piece_move_ctrl_candidate #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_cand (
    .i_pose         (r_pose),
    .i_kind         (w_kind),
    .i_kick         (w_kick),
    .o_cand         (w_cand),
    .o_out_of_range (w_oor)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pose      <= SPAWN_POSE;
      r_cand      <= SPAWN_POSE;
      r_kind      <= MV_DOWN;
      r_collide   <= 1'b0;
      r_active    <= 1'b0;
      r_grav_pend <= 1'b0;
      r_chk_req   <= 1'b0;
      r_lock      <= 1'b0;
`ifdef PIECE_WALL_KICK_EN
      r_kick_stage <= 2'd0;
`endif
    end else begin
      r_lock <= 1'b0;
      if (bus.gravity_tick && r_active) r_grav_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.spawn) begin
            r_pose      <= SPAWN_POSE;
            r_active    <= 1'b1;
            r_grav_pend <= 1'b0;
          end else if (w_take_grav || w_take_btn) begin
            r_kind <= w_kind;
            r_cand <= w_cand;
            if (w_take_grav) r_grav_pend <= 1'b0;
            if (w_oor) begin
              r_collide <= 1'b1;
              r_state   <= ST_COMMIT;
            end else begin
              r_chk_req <= 1'b1;
              r_state   <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (bus.chk_ack) begin
            r_collide <= bus.chk_collide;
            r_chk_req <= 1'b0;
            r_state   <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
`ifdef PIECE_WALL_KICK_EN
          r_kick_stage <= 2'd0;
`endif
          if (!r_collide) begin
            r_pose <= r_cand;
          end else if (r_kind == MV_DOWN) begin
            r_lock      <= 1'b1;
            r_active    <= 1'b0;
            r_grav_pend <= 1'b0;
          end
`ifdef PIECE_WALL_KICK_EN
          else if (is_rotation(r_kind) && (r_kick_stage != 2'd2)) begin
            r_state      <= (r_kick_stage == 2'd0) ? ST_KICK_L : ST_KICK_R;
            r_kick_stage <= r_kick_stage;
          end
`endif
        end
`ifdef PIECE_WALL_KICK_EN
        ST_KICK_L: begin
          r_cand       <= w_cand;
          r_kick_stage <= 2'd1;
          if (w_oor) begin
            r_state <= ST_KICK_R;
          end else begin
            r_chk_req <= 1'b1;
            r_state   <= ST_CHECK;
          end
        end
        ST_KICK_R: begin
          r_cand       <= w_cand;
          r_kick_stage <= 2'd2;
          if (w_oor) begin
            r_kick_stage <= 2'd0;
            r_state      <= ST_IDLE;
          end else begin
            r_chk_req <= 1'b1;
            r_state   <= ST_CHECK;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.poll_inputs = w_take_btn;
  assign bus.chk_req     = r_chk_req;
  assign bus.chk_x       = r_cand.x;
  assign bus.chk_y       = r_cand.y;
  assign bus.chk_rot     = r_cand.rot;
  assign bus.piece_x     = r_pose.x;
  assign bus.piece_y     = r_pose.y;
  assign bus.piece_rot   = r_pose.rot;
  assign bus.active      = r_active;
  assign bus.lock        = r_lock;
  assign bus.state       = r_state;

endmodule
